// File: rtl/banked_reg_file.sv
// Banked file-register block for the 8-bit mini-CPU: banked RAM, INDF, TMR0 with prescaler, TRIS.
// Optional macro RAM_CLR_EN: sweeps RAM to 0x00 after reset, with busy high during the sweep.
module banked_reg_file #(
  parameter int BANKS = 4,
  parameter int PA_W  = 4,
  parameter int PB_W  = 8,
  localparam int BW   = (BANKS >= 4) ? 2 : (BANKS == 2) ? 1 : 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        f_adrs,
  input  logic              f_wr,
  input  logic [7:0]        f_in_data,
  output logic [7:0]        f_out_data,
  input  logic              C_en,
  input  logic              DC_en,
  input  logic              Z_en,
  input  logic              C_new,
  input  logic              DC_new,
  input  logic              Z_new,
  input  logic              SLEEP,
  input  logic              CLRWDT,
  input  logic              wdtmr,
  input  logic              option_wr,
  input  logic              tris_wr,
  input  logic              tris_sel,
  input  logic              tmr0_tick,
  input  logic              t0cki,
  input  logic [7:0]        PCL1,
  input  logic [PA_W-1:0]   porta_in,
  input  logic [PB_W-1:0]   portb_in,
  output logic [PA_W-1:0]   PORTA,
  output logic [PB_W-1:0]   PORTB,
  output logic [PA_W-1:0]   porta_oe,
  output logic [PB_W-1:0]   portb_oe,
  output logic [5+BW-1:0]   FSR,
  output logic              C,
  output logic              PCL_wr,
  output logic              tmr0_ovf,
  output logic              busy
);
  localparam int FSR_W = 5 + BW;
  localparam int DEPTH = 9 + 16 * BANKS;
  localparam int AW    = 7;

  logic [FSR_W-1:0] fsr_q, fsr_d;
  logic [7:0]       tmr0_q, tmr0_d, pre_q, pre_d;
  logic [1:0]       inh_q, inh_d;
  logic             ovf_q, ovf_d;
  logic [5:0]       option_q, option_d;
  logic [PA_W-1:0]  trisa_q, trisa_d, porta_q, porta_d;
  logic [PB_W-1:0]  trisb_q, trisb_d, portb_q, portb_d;
  logic [2:0]       pa_q, pa_d;
  logic             to_n_q, to_n_d, pd_n_q, pd_n_d;
  logic             z_q, z_d, dc_q, dc_d, c_q, c_d;
  logic [2:0]       t0_sync_q, t0_sync_d;
  logic [7:0]       ram_q [DEPTH];

  logic [4:0]    ea;
  logic [1:0]    bank;
  logic [AW-1:0] ram_idx, ram_waddr;
  logic [7:0]    ram_wdata, fsr_rd;
  logic          is_ram, wr, stat_wr, ram_we;

  // INDF with FSR[4:0]==0 yields EA 0, which is never written and reads as zero
  always_comb begin
    ea      = (f_adrs == 5'd0) ? fsr_q[4:0] : f_adrs;
    bank    = 2'(fsr_q >> 5);
    is_ram  = (ea >= 5'd7);
    wr      = f_wr & (ea != 5'd0);
    stat_wr = wr & (ea == 5'd3);
    ram_idx = ea[4] ? (7'd9 + {1'b0, bank, 4'b0000} + {3'b000, ea[3:0]})
                    : ({2'b00, ea} - 7'd7);
  end

`ifdef RAM_CLR_EN
  // state | meaning
  // IDLE  | normal operation, RAM accessible
  // CLEAR | sweeping RAM to 0x00, one byte per cycle, highest index first
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == '0) state_d = ST_IDLE;
      else                 clr_cnt_d = clr_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= AW'(DEPTH - 1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    ram_we    = wr & is_ram & ~busy;
    ram_waddr = ram_idx;
    ram_wdata = f_in_data;
`ifdef RAM_CLR_EN
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  always_comb begin
    fsr_rd             = 8'hFF;
    fsr_rd[FSR_W-1:0]  = fsr_q;
    case (ea)
      5'd0:    f_out_data = 8'h00;
      5'd1:    f_out_data = tmr0_q;
      5'd2:    f_out_data = PCL1;
      5'd3:    f_out_data = {pa_q, to_n_q, pd_n_q, z_q, dc_q, c_q};
      5'd4:    f_out_data = fsr_rd;
      5'd5:    f_out_data = 8'(porta_in);
      5'd6:    f_out_data = 8'(portb_in);
      default: f_out_data = busy ? 8'h00 : ram_q[ram_idx];
    endcase
  end

  always_comb begin
    fsr_d    = fsr_q;
    porta_d  = porta_q;
    portb_d  = portb_q;
    option_d = option_q;
    trisa_d  = trisa_q;
    trisb_d  = trisb_q;
    pa_d     = pa_q;
    z_d      = z_q;
    dc_d     = dc_q;
    c_d      = c_q;
    to_n_d   = to_n_q;
    pd_n_d   = pd_n_q;
    if (wr && ea == 5'd4) fsr_d   = f_in_data[FSR_W-1:0];
    if (wr && ea == 5'd5) porta_d = f_in_data[PA_W-1:0];
    if (wr && ea == 5'd6) portb_d = f_in_data[PB_W-1:0];
    if (option_wr) option_d = f_in_data[5:0];
    if (tris_wr && !tris_sel) trisa_d = f_in_data[PA_W-1:0];
    if (tris_wr && tris_sel)  trisb_d = f_in_data[PB_W-1:0];
    // ALU flag updates take priority over a STATUS write for all three flags
    if (C_en || DC_en || Z_en) begin
      if (C_en)  c_d  = C_new;
      if (DC_en) dc_d = DC_new;
      if (Z_en)  z_d  = Z_new;
    end else if (stat_wr) begin
      {z_d, dc_d, c_d} = f_in_data[2:0];
    end
    if (stat_wr) pa_d = f_in_data[7:5];
    if (CLRWDT || SLEEP || wdtmr) to_n_d = CLRWDT | SLEEP;
    if (CLRWDT || SLEEP)          pd_n_d = CLRWDT;
  end

  logic       t0cs, t0se, psa, src_ev, inc;
  logic [2:0] ps;
  logic [8:0] div;
  logic [7:0] pre_mask;

  always_comb begin
    {t0cs, t0se, psa, ps} = option_q;
    t0_sync_d = {t0_sync_q[1:0], t0cki};
    div       = 9'd2 << ps;
    pre_mask  = 8'(div - 9'd1);
    if (t0cs) src_ev = t0se ? (~t0_sync_q[1] & t0_sync_q[2]) : (t0_sync_q[1] & ~t0_sync_q[2]);
    else      src_ev = tmr0_tick;
    tmr0_d = tmr0_q;
    pre_d  = pre_q;
    inh_d  = inh_q;
    inc    = 1'b0;
    // a write wins over any increment and blanks the next two cycles
    if (wr && ea == 5'd1) begin
      tmr0_d = f_in_data;
      pre_d  = 8'h00;
      inh_d  = 2'd2;
    end else if (inh_q != 2'd0) begin
      inh_d = inh_q - 2'd1;
    end else if (src_ev) begin
      if (psa) begin
        inc = 1'b1;
      end else if (pre_q == pre_mask) begin
        pre_d = 8'h00;
        inc   = 1'b1;
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end
    if (inc) tmr0_d = tmr0_q + 8'd1;
    ovf_d = inc & (tmr0_q == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsr_q     <= '0;
      tmr0_q    <= 8'h00;
      pre_q     <= 8'h00;
      inh_q     <= 2'd0;
      ovf_q     <= 1'b0;
      option_q  <= 6'h3F;
      trisa_q   <= '1;
      trisb_q   <= '1;
      porta_q   <= '0;
      portb_q   <= '0;
      pa_q      <= 3'b000;
      to_n_q    <= 1'b1;
      pd_n_q    <= 1'b1;
      z_q       <= 1'b0;
      dc_q      <= 1'b0;
      c_q       <= 1'b0;
      t0_sync_q <= 3'b000;
    end else begin
      fsr_q     <= fsr_d;
      tmr0_q    <= tmr0_d;
      pre_q     <= pre_d;
      inh_q     <= inh_d;
      ovf_q     <= ovf_d;
      option_q  <= option_d;
      trisa_q   <= trisa_d;
      trisb_q   <= trisb_d;
      porta_q   <= porta_d;
      portb_q   <= portb_d;
      pa_q      <= pa_d;
      to_n_q    <= to_n_d;
      pd_n_q    <= pd_n_d;
      z_q       <= z_d;
      dc_q      <= dc_d;
      c_q       <= c_d;
      t0_sync_q <= t0_sync_d;
    end
  end

  assign PORTA    = porta_q;
  assign PORTB    = portb_q;
  assign porta_oe = ~trisa_q;
  assign portb_oe = ~trisb_q;
  assign FSR      = fsr_q;
  assign C        = c_q;
  assign PCL_wr   = f_wr & (ea == 5'd2);
  assign tmr0_ovf = ovf_q;

endmodule

// File: tb/tb_banked_reg_file.sv
// Scoreboard bench for banked_reg_file: driver pushes model expectations, negedge monitor compares.
module tb_banked_reg_file;
  localparam int BANKS = 4;
  localparam int PA_W  = 4;
  localparam int PB_W  = 8;
  localparam int FSR_W = 7;
  localparam int DEPTH = 9 + 16 * BANKS;
`ifdef RAM_CLR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] f_adrs;
  logic f_wr;
  logic [7:0] f_in_data, f_out_data, PCL1;
  logic C_en, DC_en, Z_en, C_new, DC_new, Z_new, SLEEP, CLRWDT, wdtmr;
  logic option_wr, tris_wr, tris_sel, tmr0_tick, t0cki;
  logic [PA_W-1:0] porta_in, PORTA, porta_oe;
  logic [PB_W-1:0] portb_in, PORTB, portb_oe;
  logic [FSR_W-1:0] FSR;
  logic C, PCL_wr, tmr0_ovf, busy;

  banked_reg_file #(.BANKS(BANKS), .PA_W(PA_W), .PB_W(PB_W)) dut (
    .clk(clk), .rst(rst), .f_adrs(f_adrs), .f_wr(f_wr), .f_in_data(f_in_data),
    .f_out_data(f_out_data), .C_en(C_en), .DC_en(DC_en), .Z_en(Z_en),
    .C_new(C_new), .DC_new(DC_new), .Z_new(Z_new), .SLEEP(SLEEP), .CLRWDT(CLRWDT),
    .wdtmr(wdtmr), .option_wr(option_wr), .tris_wr(tris_wr), .tris_sel(tris_sel),
    .tmr0_tick(tmr0_tick), .t0cki(t0cki), .PCL1(PCL1), .porta_in(porta_in),
    .portb_in(portb_in), .PORTA(PORTA), .PORTB(PORTB), .porta_oe(porta_oe),
    .portb_oe(portb_oe), .FSR(FSR), .C(C), .PCL_wr(PCL_wr), .tmr0_ovf(tmr0_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd; bit rd_chk; int c; int ovf; int pcl_wr; int porta; int portb;
    int pa_oe; int pb_oe; int fsr; int busy;
  } exp_t;
  exp_t exp_q[$];
  bit chk_v = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_fsr, m_tmr, m_pre, m_hold, m_ovf, m_opt, m_trisa, m_trisb, m_porta, m_portb;
  int m_pa, m_to, m_pd, m_z, m_dc, m_c, m_busy;
  int pin_hist[$];
  int m_common[9];
  bit m_common_v[9];
  int m_bank[4][16];
  bit m_bank_v[4][16];

  task automatic chk(string name, int act, int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty at %0t: got no entry expected one", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.rd_chk) chk("f_out_data", int'(f_out_data), e.rd);
        chk("C", int'(C), e.c);
        chk("tmr0_ovf", int'(tmr0_ovf), e.ovf);
        chk("PCL_wr", int'(PCL_wr), e.pcl_wr);
        chk("PORTA", int'(PORTA), e.porta);
        chk("PORTB", int'(PORTB), e.portb);
        chk("porta_oe", int'(porta_oe), e.pa_oe);
        chk("portb_oe", int'(portb_oe), e.pb_oe);
        chk("FSR", int'(FSR), e.fsr);
        chk("busy", int'(busy), e.busy);
      end
    end
  end

  function automatic int m_ea();
    return (f_adrs == 5'd0) ? (m_fsr & 31) : int'(f_adrs);
  endfunction

  task automatic model_reset();
    m_fsr = 0; m_tmr = 0; m_pre = 0; m_hold = 0; m_ovf = 0; m_opt = 'h3F;
    m_trisa = 'hF; m_trisb = 'hFF; m_porta = 0; m_portb = 0;
    m_pa = 0; m_to = 1; m_pd = 1; m_z = 0; m_dc = 0; m_c = 0;
    pin_hist = '{0, 0, 0};
    m_busy = CLR ? DEPTH : 0;
    if (CLR) begin
      for (int i = 0; i < 9; i++) begin m_common[i] = 0; m_common_v[i] = 1; end
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 16; i++) begin m_bank[b][i] = 0; m_bank_v[b][i] = 1; end
    end
  endtask

  task automatic model_update();
    int ea, b, d, ps, div;
    bit w, ev, inc, sw;
    ea = m_ea();
    b  = m_fsr >> 5;
    d  = int'(f_in_data);
    w  = f_wr && (ea != 0);
    sw = w && (ea == 3);
    if (w && ea >= 7 && m_busy == 0) begin
      if (ea < 16) begin m_common[ea-7] = d; m_common_v[ea-7] = 1; end
      else begin m_bank[b][ea-16] = d; m_bank_v[b][ea-16] = 1; end
    end
    if (C_en || DC_en || Z_en) begin
      if (C_en)  m_c  = int'(C_new);
      if (DC_en) m_dc = int'(DC_new);
      if (Z_en)  m_z  = int'(Z_new);
    end else if (sw) begin
      m_z = (d >> 2) & 1; m_dc = (d >> 1) & 1; m_c = d & 1;
    end
    if (sw) m_pa = d >> 5;
    if (CLRWDT || SLEEP || wdtmr) m_to = (CLRWDT || SLEEP) ? 1 : 0;
    if (CLRWDT || SLEEP) m_pd = CLRWDT ? 1 : 0;
    // a pin change is seen as a timer event two clocks after it is sampled
    if ((m_opt >> 5) & 1) begin
      if ((m_opt >> 4) & 1) ev = (pin_hist[1] == 0) && (pin_hist[2] == 1);
      else                  ev = (pin_hist[1] == 1) && (pin_hist[2] == 0);
    end else ev = tmr0_tick;
    pin_hist.push_front(int'(t0cki));
    void'(pin_hist.pop_back());
    ps  = m_opt & 7;
    div = 2 << ps;
    inc = 0;
    m_ovf = 0;
    if (w && ea == 1) begin
      m_tmr = d; m_pre = 0; m_hold = 2;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (ev) begin
      if ((m_opt >> 3) & 1) inc = 1;
      else begin
        m_pre++;
        if (m_pre == div) begin m_pre = 0; inc = 1; end
        else if (m_pre == 256) m_pre = 0;
      end
    end
    if (inc) begin
      if (m_tmr == 255) begin m_tmr = 0; m_ovf = 1; end
      else m_tmr++;
    end
    if (w && ea == 4) m_fsr = d & ((1 << FSR_W) - 1);
    if (w && ea == 5) m_porta = d & 'hF;
    if (w && ea == 6) m_portb = d & 'hFF;
    if (option_wr) m_opt = d & 'h3F;
    if (tris_wr) begin
      if (tris_sel) m_trisb = d & 'hFF;
      else          m_trisa = d & 'hF;
    end
    if (m_busy > 0) m_busy--;
  endtask

  task automatic idle_inputs();
    f_wr = 0; C_en = 0; DC_en = 0; Z_en = 0; C_new = 0; DC_new = 0; Z_new = 0;
    SLEEP = 0; CLRWDT = 0; wdtmr = 0; option_wr = 0; tris_wr = 0;
  endtask

  task automatic cyc();
    exp_t e;
    int ea;
    ea = m_ea();
    e.rd_chk = 1;
    case (ea)
      0: e.rd = 0;
      1: e.rd = m_tmr;
      2: e.rd = int'(PCL1);
      3: e.rd = (m_pa << 5) | (m_to << 4) | (m_pd << 3) | (m_z << 2) | (m_dc << 1) | m_c;
      4: e.rd = (256 - (1 << FSR_W)) | m_fsr;
      5: e.rd = int'(porta_in);
      6: e.rd = int'(portb_in);
      default: begin
        if (m_busy > 0) e.rd = 0;
        else if (ea < 16) begin e.rd = m_common[ea-7]; e.rd_chk = m_common_v[ea-7]; end
        else begin e.rd = m_bank[m_fsr>>5][ea-16]; e.rd_chk = m_bank_v[m_fsr>>5][ea-16]; end
      end
    endcase
    e.c = m_c; e.ovf = m_ovf; e.pcl_wr = (f_wr && ea == 2) ? 1 : 0;
    e.porta = m_porta; e.portb = m_portb;
    e.pa_oe = ~m_trisa & 'hF; e.pb_oe = ~m_trisb & 'hFF;
    e.fsr = m_fsr; e.busy = (m_busy > 0) ? 1 : 0;
    exp_q.push_back(e);
    chk_v = 1;
    @(posedge clk);
    model_update();
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    chk_v = 0;
    rst = 1; t0cki = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic wr_f(input int a, input int d);
    f_adrs = 5'(a); f_in_data = 8'(d); f_wr = 1; cyc();
  endtask

  task automatic rd_f(input int a);
    f_adrs = 5'(a); cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    f_adrs = 0; f_in_data = 0; PCL1 = 8'h5C; tris_sel = 0; tmr0_tick = 0;
    porta_in = 4'h9; portb_in = 8'h81;
    for (int i = 0; i < 9; i++) m_common_v[i] = 0;
    for (int b = 0; b < 4; b++) for (int i = 0; i < 16; i++) m_bank_v[b][i] = 0;
    do_reset();
    if (CLR) repeat (DEPTH) rd_f(3);

    // reset state; OPTION resets to external clock so the tick is ignored
    tmr0_tick = 1;
    rd_f(3); rd_f(4); rd_f(2);
    repeat (4) rd_f(1);
    tmr0_tick = 0;

    // banking and indirect addressing
    wr_f(4, 'h30); wr_f('h10, 'hA5); wr_f(4, 'h10); wr_f('h10, 'h5A);
    wr_f(4, 'h30); rd_f(0); rd_f('h10);
    wr_f(4, 'h10); rd_f(0); rd_f('h10);
    wr_f('h08, 'h77);
    for (int b = 0; b < 4; b++) begin wr_f(4, b << 5); rd_f('h08); end
    wr_f(4, 'h60); wr_f(0, 'h55); rd_f(0);
    wr_f(4, 'h06); rd_f(0); wr_f(4, 'h03); rd_f(0);

    // internal clock, prescaler /4, then a write near wrap
    f_in_data = 8'h01; option_wr = 1; cyc();
    tmr0_tick = 1;
    repeat (14) rd_f(1);
    wr_f(1, 'hFE);
    repeat (14) rd_f(1);
    tmr0_tick = 0;

    // flags
    C_en = 1; C_new = 0; wr_f(3, 'hE7);
    wr_f(3, 'h07); rd_f(3);
    Z_en = 1; Z_new = 0; DC_en = 1; DC_new = 0; rd_f(3);
    SLEEP = 1; rd_f(3); rd_f(3);
    CLRWDT = 1; rd_f(3);
    wdtmr = 1; rd_f(3); rd_f(3);

    // TRIS and ports
    tris_sel = 1; f_in_data = 8'h0F; tris_wr = 1; cyc();
    wr_f(6, 'h3C); rd_f(6);
    tris_sel = 0; f_in_data = 8'h05; tris_wr = 1; cyc();
    wr_f(5, 'hF6); rd_f(5);
    wr_f(2, 'h11);

    // external clock, rising then falling edges, no prescaler
    f_in_data = 8'h28; option_wr = 1; cyc();
    for (int i = 0; i < 24; i++) begin t0cki = 1'((i >> 1) & 1); rd_f(1); end
    f_in_data = 8'h38; option_wr = 1; cyc();
    for (int i = 0; i < 24; i++) begin t0cki = 1'((i >> 1) & 1); rd_f(1); end
    t0cki = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      f_adrs = 5'($urandom_range(0, 31));
      f_wr = 1'($urandom_range(0, 1));
      f_in_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        C_en = 1'($urandom); DC_en = 1'($urandom); Z_en = 1'($urandom);
        C_new = 1'($urandom); DC_new = 1'($urandom); Z_new = 1'($urandom);
      end
      SLEEP  = ($urandom_range(0, 15) == 0);
      CLRWDT = ($urandom_range(0, 15) == 0);
      wdtmr  = ($urandom_range(0, 15) == 0);
      option_wr = ($urandom_range(0, 31) == 0);
      tris_wr   = ($urandom_range(0, 15) == 0);
      tris_sel  = 1'($urandom);
      tmr0_tick = 1'($urandom);
      t0cki     = 1'($urandom);
      porta_in  = 4'($urandom);
      portb_in  = 8'($urandom);
      PCL1      = 8'($urandom);
      cyc();
    end
    tmr0_tick = 0; t0cki = 0;

    // reset mid-run, write during any clear sweep, then read every RAM location
    do_reset();
    wr_f('h08, 'hAA);
    wr_f('h11, 'hBB);
    repeat (DEPTH + 2) rd_f('h08);
    for (int b = 0; b < 4; b++) begin
      wr_f(4, b << 5);
      for (int a = 7; a < 32; a++) rd_f(a);
    end

    chk_v = 0;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
